// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a length-prefixed, XOR-checksummed
// byte stream into 16-bit imem writes while holding the CPU.
module imem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_END   = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        xfer_s;
    logic [7:0]  addr_r;
    logic [8:0]  rem_r;
    logic [7:0]  acc_r;
    logic [15:0] wr_data_r;
    logic        wr_en_r;
    logic        ready_r;
    logic        hold_r;
    logic        done_r;
    logic        err_r;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // ready_r mirrors the current state's accept decode, so a handshake needs no input path
    assign xfer_s   = in_valid & ready_r;
    assign in_ready = ready_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = addr_r;
    assign wr_data  = wr_data_r;
    assign cpu_hold = hold_r;
    assign done     = done_r;
    assign err      = err_r;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (start)  state_s = S_LEN;   else state_s = S_IDLE;
            S_LEN:   if (xfer_s) state_s = S_HI;    else state_s = S_LEN;
            S_HI:    if (xfer_s) state_s = S_LO;    else state_s = S_HI;
            S_LO:    if (xfer_s) state_s = S_WRITE; else state_s = S_LO;
            S_WRITE: if (rem_r == 9'd1) state_s = S_CHK; else state_s = S_HI;
            S_CHK:   if (xfer_s) state_s = S_END;   else state_s = S_CHK;
            S_END:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: address, remaining count, checksum and assembled word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= 8'h00;
            rem_r     <= 9'd0;
            acc_r     <= 8'h00;
            wr_data_r <= 16'h0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        addr_r <= 8'h00;
                        acc_r  <= 8'h00;
                    end
                end
                S_LEN: begin
                    if (xfer_s) begin
                        // a zero length byte encodes a full 256-word image
                        rem_r <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        acc_r <= chk_next(acc_r, in_data);
                    end
                end
                S_HI: begin
                    if (xfer_s) begin
                        wr_data_r[15:8] <= in_data;
                        acc_r           <= chk_next(acc_r, in_data);
                    end
                end
                S_LO: begin
                    if (xfer_s) begin
                        wr_data_r[7:0] <= in_data;
                        acc_r          <= chk_next(acc_r, in_data);
                    end
                end
                S_WRITE: begin
                    addr_r <= addr_r + 8'd1;
                    rem_r  <= rem_r - 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered strobes and status, decoded one cycle ahead from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r <= 1'b0;
            ready_r <= 1'b0;
            hold_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            wr_en_r <= (state_s == S_WRITE);
            ready_r <= (state_s == S_LEN) || (state_s == S_HI) ||
                       (state_s == S_LO)  || (state_s == S_CHK);
            hold_r  <= (state_s != S_IDLE);
            done_r  <= (state_r == S_CHK) && xfer_s && (in_data == acc_r);
            err_r   <= (state_r == S_CHK) && xfer_s && (in_data != acc_r);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus stall, 256-word
// and mid-session reset sequences checked against a write log.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [23:0] wq[$];
    int          done_cnt = 0;
    int          err_cnt = 0;

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/status log sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    typedef struct {
        logic        start;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic        hold;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic r, input logic w, input logic [7:0] a,
                                input logic [15:0] wd, input logic h, input logic dn,
                                input logic er);
        vec_t t;
        t.start = s; t.vld = v; t.dat = d; t.rdy = r; t.we = w;
        t.addr = a; t.wd = wd; t.hold = h; t.dn = dn; t.er = er;
        return t;
    endfunction

    function automatic logic [28:0] outs();
        return {in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        in_valid = 1'b0;
    endtask

    task automatic run_session(input logic [7:0] bytes[$], input int gap);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (bytes[k]) send_byte(bytes[k], gap);
        for (int k = 0; k < 10 && cpu_hold; k++) @(negedge clk);
        chk("session_end_hold", {31'd0, cpu_hold}, 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        int base, d0, e0, bad, rdy_hi;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_state", {3'd0, outs()}, 32'd0);
        rst_n = 1'b1;

        // Good checksum session, continuous stream
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,16'h0000,1,0,0));
        tbl.push_back(mk(0,1,8'h02, 1,0,8'h00,16'h0000,1,0,0));
        tbl.push_back(mk(0,1,8'h12, 1,0,8'h00,16'h1200,1,0,0));
        tbl.push_back(mk(0,1,8'h34, 0,1,8'h00,16'h1234,1,0,0));
        tbl.push_back(mk(0,1,8'hAB, 1,0,8'h01,16'h1234,1,0,0));
        tbl.push_back(mk(0,1,8'hAB, 1,0,8'h01,16'hAB34,1,0,0));
        tbl.push_back(mk(0,1,8'hCD, 0,1,8'h01,16'hABCD,1,0,0));
        tbl.push_back(mk(0,1,8'h42, 1,0,8'h02,16'hABCD,1,0,0));
        tbl.push_back(mk(0,1,8'h42, 0,0,8'h02,16'hABCD,1,1,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h02,16'hABCD,0,0,0));
        // in_valid in IDLE ignored; start in HI/WRITE ignored
        tbl.push_back(mk(0,1,8'h55, 0,0,8'h02,16'hABCD,0,0,0));
        tbl.push_back(mk(1,1,8'h01, 1,0,8'h00,16'hABCD,1,0,0));
        tbl.push_back(mk(0,1,8'h01, 1,0,8'h00,16'hABCD,1,0,0));
        tbl.push_back(mk(1,1,8'h5A, 1,0,8'h00,16'h5ACD,1,0,0));
        tbl.push_back(mk(1,1,8'h3C, 0,1,8'h00,16'h5A3C,1,0,0));
        tbl.push_back(mk(1,1,8'h67, 1,0,8'h01,16'h5A3C,1,0,0));
        tbl.push_back(mk(0,1,8'h67, 0,0,8'h01,16'h5A3C,1,1,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h01,16'h5A3C,0,0,0));
        // Bad checksum: writes still issued, err pulse
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,16'h5A3C,1,0,0));
        tbl.push_back(mk(0,1,8'h02, 1,0,8'h00,16'h5A3C,1,0,0));
        tbl.push_back(mk(0,1,8'h12, 1,0,8'h00,16'h123C,1,0,0));
        tbl.push_back(mk(0,1,8'h34, 0,1,8'h00,16'h1234,1,0,0));
        tbl.push_back(mk(0,1,8'hAB, 1,0,8'h01,16'h1234,1,0,0));
        tbl.push_back(mk(0,1,8'hAB, 1,0,8'h01,16'hAB34,1,0,0));
        tbl.push_back(mk(0,1,8'hCD, 0,1,8'h01,16'hABCD,1,0,0));
        tbl.push_back(mk(0,1,8'h43, 1,0,8'h02,16'hABCD,1,0,0));
        tbl.push_back(mk(0,1,8'h43, 0,0,8'h02,16'hABCD,1,0,1));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h02,16'hABCD,0,0,0));

        foreach (tbl[i]) begin
            start    = tbl[i].start;
            in_valid = tbl[i].vld;
            in_data  = tbl[i].dat;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {3'd0, outs()},
                {3'd0, tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd,
                 tbl[i].hold, tbl[i].dn, tbl[i].er});
        end
        start = 1'b0; in_valid = 1'b0;

        // Stalled stream: same writes, single done
        base = wq.size(); d0 = done_cnt; e0 = err_cnt;
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_session(q, 5);
        chk("stall_wcount", wq.size() - base, 32'd2);
        if (wq.size() - base >= 2) begin
            chk("stall_w0", {8'd0, wq[base]}, 32'h00_001234);
            chk("stall_w1", {8'd0, wq[base+1]}, 32'h00_01ABCD);
        end
        chk("stall_done", done_cnt - d0, 32'd1);
        chk("stall_err", err_cnt - e0, 32'd0);

        // 256-word image, words equal to index, checksum 00
        base = wq.size(); d0 = done_cnt; e0 = err_cnt;
        q = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            q.push_back(8'h00);
            q.push_back(i[7:0]);
        end
        q.push_back(8'h00);
        run_session(q, 0);
        chk("n256_wcount", wq.size() - base, 32'd256);
        bad = 0;
        if (wq.size() - base >= 256) begin
            for (int i = 0; i < 256; i++)
                if (wq[base+i] !== {i[7:0], 8'h00, i[7:0]}) bad++;
            chk("n256_last", {8'd0, wq[base+255]}, 32'h00_FF00FF);
        end
        chk("n256_words_bad", bad, 32'd0);
        chk("n256_done", done_cnt - d0, 32'd1);
        chk("n256_addr_wrap", {24'd0, wr_addr}, 32'd0);

        // Reset mid-session after the first write
        base = wq.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        chk("rst_first_we", {31'd0, wr_en}, 32'd1);
        in_valid = 1'b1; in_data = 8'hAB;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outs", {3'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_hi = 0;
        for (int k = 0; k < 6; k++) begin
            in_data = 8'hCD;
            @(negedge clk);
            if (in_ready || cpu_hold) rdy_hi++;
        end
        in_valid = 1'b0;
        chk("rst_idle_after", rdy_hi, 32'd0);
        chk("rst_wcount", wq.size() - base, 32'd1);
        if (wq.size() - base >= 1)
            chk("rst_w0", {8'd0, wq[base]}, 32'h00_001234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
